// File: rtl/alu_serial_adder32_if.sv
// Handshake and operand/result bundle for the byte-serial 32-bit add/subtract unit.
// The master side issues operations; the slave side is the adder.
interface alu_serial_adder32_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, carry_out, overflow, zero
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, carry_out, overflow, zero
    );
endinterface

// File: rtl/alu_serial_adder32.sv
// Byte-serial WIDTH-bit add/subtract: one SLICE-bit adder stepped LSB-first over
// NSLICE slices with a registered carry; flags are produced with the last slice.
module alu_serial_adder32 #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_serial_adder32_if.slave  bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                        state, state_n;
    logic [CW-1:0]                 cnt;
    logic                          cy;
    logic [NSLICE-1:0][SLICE-1:0]  a_q, b_q, res_q, res_n;
    logic [SLICE:0]                ss;
    logic                          accept, last;
    logic                          carry_q, ovf_q, zero_q;

    // 8-bit slice adder: two unsigned bytes in, 9-bit sum out.
    function automatic logic [SLICE:0] alu_adder(input logic [SLICE-1:0] x,
                                                 input logic [SLICE-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    always_comb begin
        accept = bus.start && (state != RUN);
        last   = (cnt == CW'(NSLICE - 1));
        // Max 255 + 255 + 1 = 511, so the slice sum never exceeds 9 bits.
        ss     = alu_adder(a_q[cnt], b_q[cnt]) + {{SLICE{1'b0}}, cy};
        res_n      = res_q;
        res_n[cnt] = ss[SLICE-1:0];
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = RUN;
            RUN:     if (last)   state_n = DONE;
            DONE:    state_n = accept ? RUN : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Operand capture on accept, one slice per cycle in RUN, flags with the last slice.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            cy      <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else if (accept) begin
            a_q <= bus.a;
            b_q <= bus.sub ? ~bus.b : bus.b;
            cy  <= bus.sub;
            cnt <= '0;
        end else if (state == RUN) begin
            res_q <= res_n;
            cy    <= ss[SLICE];
            cnt   <= cnt + 1'b1;
            if (last) begin
                carry_q <= ss[SLICE];
                ovf_q   <= (a_q[NSLICE-1][SLICE-1] == b_q[NSLICE-1][SLICE-1]) &&
                           (res_n[NSLICE-1][SLICE-1] != a_q[NSLICE-1][SLICE-1]);
                zero_q  <= (res_n == '0);
            end
        end
    end

    assign bus.busy      = (state == RUN);
    assign bus.done      = (state == DONE);
    assign bus.result    = res_q;
    assign bus.carry_out = carry_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: doc/alu_serial_adder32.md
Name: alu_serial_adder32

Overview:
- Byte-serial 32-bit add/subtract unit for the MIPS-32 ALU path.
- Wraps one instance of the existing 8-bit `alu_adder` (8-bit A/B in, 9-bit Sum out) and sequences four byte slices through it, LSB first, with a registered carry chain.
- Sits between the operand/ID-EX register and the ALU result mux.
- Trades latency for area versus a flat 32-bit adder.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of SLICE.
- SLICE, 8, slice width; fixed by `alu_adder`.
- NSLICE, WIDTH/SLICE = 4, slices per operation (derived localparam).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- sub  input  1  0 = A+B, 1 = A-B; captured with start
- a  input  32  operand A; captured with start
- b  input  32  operand B; captured with start
- busy  output  1  high while slices are in progress (RUN)
- done  output  1  one-cycle pulse, result/flags valid
- result  output  32  sum/difference; held until next accepted start
- carry_out  output  1  carry from bit 31; for sub, 1 = no borrow
- overflow  output  1  signed two's-complement overflow
- zero  output  1  result == 0

Behaviour:
- Reset (async, active-high): state=IDLE, slice count=0, carry register=0, busy=0, done=0, result=0, carry_out=0, overflow=0, zero=0.
  - Reset asserted mid-operation aborts immediately; no done pulse follows.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 → capture a; capture b (inverted when sub=1); carry register = sub; count=0; go to RUN.
  - RUN: busy=1. Each edge processes slice[count]:
    - slice_sum9 = alu_adder(a_slice, b_slice) + carry register. Max value 511, fits 9 bits.
    - result[count*8 +: 8] ← slice_sum9[7:0]; carry register ← slice_sum9[8]; count++.
    - After the edge processing count=NSLICE-1, go to DONE.
  - DONE: done=1 for exactly this cycle; busy=0. Then:
    - start=1 → behaves as IDLE accept (back-to-back ops allowed; done still pulses once per op);
    - otherwise go to IDLE.
- Latency: start sampled at edge E0 → slices processed at E1..E4 → done high between E4 and E5. That is 4 cycles from accept to done.
- start while in RUN is ignored; operands are not recaptured and the in-flight op is unaffected.
- a/b/sub may change after the accept edge without effect.
- Flags registered at E4, together with the final slice write:
  - carry_out = final carry register;
  - overflow = (a[31] == b_eff[31]) && (result[31] != a[31]), where b_eff is b after the sub inversion;
  - zero = (all 32 result bits == 0).
- result and flags hold through IDLE until the next accept. They are not cleared at accept; the result bytes update slice-wise during RUN.
- Wrap-around: arithmetic is modulo 2^32; the carry is reported only via carry_out.

Test Plan:
- Reset mid-op:
  - start a=0x12345678, b=1; assert reset after E2 → all outputs 0, state IDLE, no done.
  - Release reset, start a=3, b=4 → done at E4, result=7.
- Low-byte sanity (matches `alu_adder` vectors): a=81, b=135, sub=0 → result=216, carry_out=0, overflow=0, zero=0.
  - a=226, b=159 → result=385 (0x181); carry crosses byte 0→1.
- Full carry ripple: a=0xFFFFFFFF, b=0x00000001 → result=0, carry_out=1, zero=1, overflow=0.
  - busy high exactly 4 cycles; done one cycle.
- Signed overflow:
  - a=0x7FFFFFFF, b=1 → result=0x80000000, overflow=1, carry_out=0.
  - sub, a=0x80000000, b=1 → result=0x7FFFFFFF, overflow=1, carry_out=1.
- Subtract with borrow: sub=1, a=5, b=7 → result=0xFFFFFFFE, carry_out=0, overflow=0.
- Handshake:
  - start held high during RUN with different a/b → ignored.
  - start in DONE cycle (a=10, b=20) → accepted; second done 4 cycles later, result=30.
